instr_decode_stage: RTL



---
 rtl/instr_decode_stage_pkg.sv | 41 ++++
 rtl/instr_decode_stage_ucode_map_rom.sv | 14 +
 rtl/instr_decode_stage.sv | 137 +++++++++++++
 3 files changed

// File: rtl/instr_decode_stage_pkg.sv
// Shared definitions for the decode stage: bus layout, opcode classes and the
// micro-code start-address/count table.
package instr_decode_stage_pkg;

  localparam int BUS_W     = 92;
  localparam int INSTR_LSB = 0;
  localparam int UADDR_LSB = 32;
  localparam int UCNT_LSB  = 40;
  localparam int RD_LSB    = 43;
  localparam int RS1_LSB   = 48;
  localparam int RS2_LSB   = 53;
  localparam int IMM_LSB   = 58;
  localparam int NTA_LSB   = 75;
  localparam int BRA_LSB   = 83;
  localparam int PRED_BIT  = 91;

  localparam logic [5:0] OPC_NOP       = 6'h00;
  localparam logic [5:0] OPC_BR_LO     = 6'h20;
  localparam logic [5:0] OPC_BR_HI_DEF = 6'h27;
  localparam logic [7:0] NOP_UADDR_DEF = 8'h00;

  // Returns {uaddr, ucnt}; ucnt is the micro-op count minus one.
  function automatic logic [10:0] ucode_rom(input logic [5:0] opc,
                                            input logic [7:0] nop_uaddr);
    case (opc)
      OPC_NOP: return {nop_uaddr, 3'd0};
      6'h01:   return {8'h10, 3'd2};
      6'h02:   return {8'h18, 3'd1};
      6'h03:   return {8'h20, 3'd3};
      6'h04:   return {8'h28, 3'd0};
      6'h05:   return {8'h30, 3'd4};
      6'h08:   return {8'h40, 3'd5};
      6'h09:   return {8'h48, 3'd7};
      6'h20, 6'h21, 6'h22, 6'h23,
      6'h24, 6'h25, 6'h26, 6'h27:
               return {8'h80, 3'd1};
      default: return {nop_uaddr, 3'd0};
    endcase
  endfunction

endpackage

// File: rtl/instr_decode_stage_ucode_map_rom.sv
// Combinational opcode to micro-code entry lookup.
module ucode_map_rom
  import instr_decode_stage_pkg::*;
#(
  parameter logic [7:0] NOP_UADDR = NOP_UADDR_DEF
) (
  input  logic [5:0] opcode,
  output logic [7:0] uaddr,
  output logic [2:0] ucnt
);

  assign {uaddr, ucnt} = ucode_rom(opcode, NOP_UADDR);

endmodule

// File: rtl/instr_decode_stage.sv
// Decode stage: registers one instruction per accepted cycle, looks up its
// micro-code entry, predicts conditional branches and drives the CU bus.
module instr_decode_stage
  import instr_decode_stage_pkg::*;
#(
  parameter int         BHT_DEPTH = 16,
  parameter logic [7:0] NOP_UADDR = NOP_UADDR_DEF,
  parameter logic [5:0] BR_OPC_HI = OPC_BR_HI_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush_pipeline,
  input  logic [31:0] instr_in,
  input  logic [7:0]  instr_addr_in,
  input  logic        instr_valid_in,
  input  logic        exec_ready,
  input  logic        br_update_valid,
  input  logic [7:0]  br_update_addr,
  input  logic        br_update_taken,
  output logic [91:0] idecode_cu_interface,
  output logic        stall_fetch,
  output logic        pred_redirect,
  output logic [7:0]  pred_target
);

  localparam int IDX_W = $clog2(BHT_DEPTH);
  localparam logic [BUS_W-1:0] BUBBLE = {52'b0, NOP_UADDR, 32'b0};

  logic [BUS_W-1:0] bus_q, bus_d, dec_bus;
  logic             out_valid_q, out_valid_d;
  logic             pred_redirect_q, pred_redirect_d;
  logic [7:0]       pred_target_q, pred_target_d;
  logic [1:0]       bht_q [BHT_DEPTH];
  logic [1:0]       bht_d [BHT_DEPTH];

  logic [5:0]       opcode;
  logic [7:0]       rom_uaddr;
  logic [2:0]       rom_ucnt;
  logic             is_branch, pred_taken, load;
  logic [IDX_W-1:0] lk_idx, upd_idx;
  logic [7:0]       br_target;
  logic             unused_upd_bits;

  assign opcode  = instr_in[31:26];
  assign lk_idx  = instr_addr_in[IDX_W-1:0];
  assign upd_idx = br_update_addr[IDX_W-1:0];
  assign unused_upd_bits = ^br_update_addr[7:IDX_W];

  ucode_map_rom #(.NOP_UADDR(NOP_UADDR)) u_rom (
    .opcode (opcode),
    .uaddr  (rom_uaddr),
    .ucnt   (rom_ucnt)
  );

  // Lookup reads the registered counter, so a same-cycle update is not seen.
  assign is_branch  = (opcode >= OPC_BR_LO) && (opcode <= BR_OPC_HI);
  assign pred_taken = is_branch && bht_q[lk_idx][1];
  assign br_target  = instr_addr_in + instr_in[7:0];
  assign load       = !out_valid_q || exec_ready;

  always_comb begin
    dec_bus = '0;
    dec_bus[INSTR_LSB +: 32] = instr_in;
    dec_bus[UADDR_LSB +: 8]  = rom_uaddr;
    dec_bus[UCNT_LSB  +: 3]  = rom_ucnt;
    dec_bus[RD_LSB    +: 5]  = instr_in[25:21];
    dec_bus[RS1_LSB   +: 5]  = instr_in[20:16];
    dec_bus[RS2_LSB   +: 5]  = instr_in[15:11];
    dec_bus[IMM_LSB   +: 17] = instr_in[16:0];
    dec_bus[NTA_LSB   +: 8]  = instr_addr_in + 8'd1;
    dec_bus[BRA_LSB   +: 8]  = instr_addr_in;
    dec_bus[PRED_BIT]        = pred_taken;
  end

  always_comb begin
    bus_d           = bus_q;
    out_valid_d     = out_valid_q;
    pred_redirect_d = 1'b0;
    pred_target_d   = pred_target_q;
    if (flush_pipeline) begin
      bus_d       = BUBBLE;
      out_valid_d = 1'b0;
    end else if (load) begin
      if (instr_valid_in) begin
        bus_d       = dec_bus;
        out_valid_d = 1'b1;
        if (pred_taken) begin
          pred_redirect_d = 1'b1;
          pred_target_d   = br_target;
        end
      end else begin
        bus_d       = BUBBLE;
        out_valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus_q           <= BUBBLE;
      out_valid_q     <= 1'b0;
      pred_redirect_q <= 1'b0;
      pred_target_q   <= 8'h00;
    end else begin
      bus_q           <= bus_d;
      out_valid_q     <= out_valid_d;
      pred_redirect_q <= pred_redirect_d;
      pred_target_q   <= pred_target_d;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < BHT_DEPTH; gi++) begin : g_bht
      always_comb begin
        bht_d[gi] = bht_q[gi];
        if (br_update_valid && (upd_idx == IDX_W'(gi))) begin
          if (br_update_taken && (bht_q[gi] != 2'b11))
            bht_d[gi] = bht_q[gi] + 2'b01;
          else if (!br_update_taken && (bht_q[gi] != 2'b00))
            bht_d[gi] = bht_q[gi] - 2'b01;
        end
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst) bht_q[gi] <= 2'b01;
        else     bht_q[gi] <= bht_d[gi];
      end
    end
  endgenerate

  assign idecode_cu_interface = bus_q;
  assign stall_fetch          = out_valid_q && !exec_ready;
  assign pred_redirect        = pred_redirect_q;
  assign pred_target          = pred_target_q;

endmodule
